// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle fetch/decode/execute/writeback controller with ALU
module multicycle_control #(
    parameter int REG_ADDR_W = 1,
    parameter int PC_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [7:0]            instr_data,
    output logic [PC_W-1:0]       instr_addr,
    output logic [REG_ADDR_W-1:0] read_reg1,
    output logic [REG_ADDR_W-1:0] read_reg2,
    input  logic [7:0]            read_data1,
    input  logic [7:0]            read_data2,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [7:0]            write_data,
    output logic                  reg_write,
    output logic                  halted,
    output logic [15:0]           retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_LI   = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t                state;
    state_t                state_nx;
    logic [PC_W-1:0]       pc;
    logic [7:0]            ir;
    logic [7:0]            a_q;
    logic [7:0]            b_q;
    logic [7:0]            alu_out;
    logic [7:0]            alu_res;
    logic [REG_ADDR_W-1:0] last_wr_reg;
    logic [7:0]            last_wr_data;

    logic [2:0]            op;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [2:0]            imm;
    logic [7:0]            imm_sext8;
    logic [PC_W-1:0]       imm_sext_pc;
    logic [PC_W-1:0]       pc_seq;
    logic [PC_W-1:0]       pc_branch;

    assign op          = ir[7:5];
    assign rs          = REG_ADDR_W'(ir[4]);
    assign rt          = REG_ADDR_W'(ir[3]);
    assign imm         = ir[2:0];
    assign imm_sext8   = {{5{imm[2]}}, imm};
    assign imm_sext_pc = {{(PC_W-3){imm[2]}}, imm};
    assign pc_seq      = pc + PC_W'(1);
    assign pc_branch   = pc_seq + imm_sext_pc;

    // ALU: operands come from A/B captured in DECODE, so rs==rt sees the pre-write value
    always_comb begin
        alu_res = 8'd0;
        case (op)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_ADDI: alu_res = a_q + imm_sext8;
            OP_LI:   alu_res = {5'b0, imm};
            default: alu_res = 8'd0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; run is only looked at in IDLE and at instruction boundaries
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      state_nx = run ? S_FETCH : S_IDLE;
            S_FETCH:     state_nx = S_DECODE;
            S_DECODE:    state_nx = (op == OP_HALT) ? S_HALTED : S_EXECUTE;
            S_EXECUTE:   begin
                if (op == OP_BEQ) begin
                    state_nx = run ? S_FETCH : S_IDLE;
                end else begin
                    state_nx = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_nx = run ? S_FETCH : S_IDLE;
            S_HALTED:    state_nx = S_HALTED;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Datapath registers: IR, operand latches, ALU result, PC, retire counter, writeback hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc           <= '0;
            ir           <= 8'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            alu_out      <= 8'd0;
            retired      <= 16'd0;
            last_wr_reg  <= '0;
            last_wr_data <= 8'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= instr_data;
                end
                S_DECODE: begin
                    a_q <= read_data1;
                    b_q <= read_data2;
                    if (op == OP_HALT) begin
                        retired <= retired + 16'd1;
                    end
                end
                S_EXECUTE: begin
                    alu_out <= alu_res;
                    if (op == OP_BEQ) begin
                        pc      <= (a_q == b_q) ? pc_branch : pc_seq;
                        retired <= retired + 16'd1;
                    end
                end
                S_WRITEBACK: begin
                    pc           <= pc_seq;
                    retired      <= retired + 16'd1;
                    last_wr_reg  <= rs;
                    last_wr_data <= alu_out;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the registered state; write port holds its last value outside WRITEBACK
    always_comb begin
        instr_addr = pc;
        read_reg1  = rs;
        read_reg2  = rt;
        reg_write  = (state == S_WRITEBACK);
        halted     = (state == S_HALTED);
        write_reg  = (state == S_WRITEBACK) ? rs : last_wr_reg;
        write_data = (state == S_WRITEBACK) ? alu_out : last_wr_data;
    end

endmodule
